// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage controller for the 16-bit CPU: drives the shared
// memory port handshake, PC/IR/register-file strobes and the retired-instruction count.
module stage_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic [2:0]       stage,
    output logic             read_m,
    output logic             write_m,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             wwd_en,
    output logic             halted,
    output logic [CNT_W-1:0] num_inst
);

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [1:0] SRC_PC1    = 2'd0;
    localparam logic [1:0] SRC_BRANCH = 2'd1;
    localparam logic [1:0] SRC_JUMP   = 2'd2;
    localparam logic [1:0] SRC_REG    = 2'd3;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } stage_e;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_IMM,
        CL_BRANCH,
        CL_LWD,
        CL_SWD,
        CL_JMP,
        CL_JAL,
        CL_JPR,
        CL_JRL,
        CL_WWD,
        CL_HLT,
        CL_NOP
    } class_e;

    stage_e     stage_q;
    stage_e     stage_d;
    logic       halted_q;
    class_e     inst_class;

    logic       rd_c;
    logic       wr_c;
    logic       iord_c;
    logic       irw_c;
    logic       pcw_c;
    logic [1:0] src_c;
    logic       rw_c;
    logic       m2r_c;
    logic       wwd_c;

    // Instruction class; undefined opcodes and R-type funcs collapse to NOP.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        inst_class = CL_NOP;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: inst_class = CL_BRANCH;
            OP_ADI, OP_ORI, OP_LHI:         inst_class = CL_IMM;
            OP_LWD:                         inst_class = CL_LWD;
            OP_SWD:                         inst_class = CL_SWD;
            OP_JMP:                         inst_class = CL_JMP;
            OP_JAL:                         inst_class = CL_JAL;
            OP_RTYPE: begin
                if (func[5:3] == 3'b000) begin
                    inst_class = CL_ALU;
                end else begin
                    case (func)
                        FN_JPR:  inst_class = CL_JPR;
                        FN_JRL:  inst_class = CL_JRL;
                        FN_WWD:  inst_class = CL_WWD;
                        FN_HLT:  inst_class = CL_HLT;
                        default: inst_class = CL_NOP;
                    endcase
                end
            end
            default: inst_class = CL_NOP;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        iord_c  = 1'b0;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        src_c   = SRC_PC1;
        rw_c    = 1'b0;
        m2r_c   = 1'b0;
        wwd_c   = 1'b0;

        case (stage_q)
            ST_IF: begin
                rd_c = 1'b1;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    stage_d = ST_ID;
                end
            end

            ST_ID: begin
                case (inst_class)
                    CL_JMP, CL_JAL: begin
                        pcw_c   = 1'b1;
                        src_c   = SRC_JUMP;
                        rw_c    = (inst_class == CL_JAL);
                        stage_d = ST_IF;
                    end
                    CL_JPR, CL_JRL: begin
                        pcw_c   = 1'b1;
                        src_c   = SRC_REG;
                        rw_c    = (inst_class == CL_JRL);
                        stage_d = ST_IF;
                    end
                    CL_WWD: begin
                        wwd_c   = 1'b1;
                        pcw_c   = 1'b1;
                        stage_d = ST_IF;
                    end
                    CL_HLT: stage_d = ST_HALT;
                    CL_NOP: begin
                        pcw_c   = 1'b1;
                        stage_d = ST_IF;
                    end
                    default: stage_d = ST_EX;
                endcase
            end

            ST_EX: begin
                case (inst_class)
                    CL_BRANCH: begin
                        pcw_c   = 1'b1;
                        src_c   = branch_taken ? SRC_BRANCH : SRC_PC1;
                        stage_d = ST_IF;
                    end
                    CL_LWD, CL_SWD: stage_d = ST_MEM;
                    default:        stage_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                iord_c = 1'b1;
                if (inst_class == CL_LWD) begin
                    rd_c = 1'b1;
                    if (mem_ready) stage_d = ST_WB;
                end else begin
                    wr_c = 1'b1;
                    if (mem_ready) begin
                        pcw_c   = 1'b1;
                        stage_d = ST_IF;
                    end
                end
            end

            ST_WB: begin
                rw_c    = 1'b1;
                pcw_c   = 1'b1;
                m2r_c   = (inst_class == CL_LWD);
                stage_d = ST_IF;
            end

            ST_HALT: stage_d = ST_HALT;

            default: stage_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q  <= ST_IF;
            halted_q <= 1'b0;
            num_inst <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            stage_q  <= stage_d;
            halted_q <= (stage_d == ST_HALT);
            if (pcw_c) num_inst <= num_inst + CNT_W'(1);
        end
    end

    // Reset kills every strobe combinationally, even mid-access, before the next edge.
    assign stage      = stage_q;
    assign halted     = halted_q;
    assign read_m     = rd_c   & reset_n;
    assign write_m    = wr_c   & reset_n;
    assign iord       = iord_c & reset_n;
    assign ir_write   = irw_c  & reset_n;
    assign pc_write   = pcw_c  & reset_n;
    assign pc_src     = reset_n ? src_c : SRC_PC1;
    assign reg_write  = rw_c   & reset_n;
    assign mem_to_reg = m2r_c  & reset_n;
    assign wwd_en     = wwd_c  & reset_n;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(read_m && write_m));
    a_pc_ir_excl: assert property (@(posedge clk) disable iff (!reset_n) !(pc_write && ir_write));

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer: per-cycle output vectors per instruction class.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        branch_taken;
    logic        mem_ready;

    logic [2:0]  stage, stage_s;
    logic        read_m, write_m, iord, ir_write, pc_write;
    logic        read_m_s, write_m_s, iord_s, ir_write_s, pc_write_s;
    logic [1:0]  pc_src, pc_src_s;
    logic        reg_write, mem_to_reg, wwd_en, halted;
    logic        reg_write_s, mem_to_reg_s, wwd_en_s, halted_s;
    logic [15:0] num_inst;
    logic [2:0]  num_inst_s;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage(stage), .read_m(read_m), .write_m(write_m), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .wwd_en(wwd_en),
        .halted(halted), .num_inst(num_inst)
    );

    // Narrow-counter copy on the same stimulus exposes counter wrap-around.
    stage_sequencer #(.CNT_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage(stage_s), .read_m(read_m_s), .write_m(write_m_s), .iord(iord_s),
        .ir_write(ir_write_s), .pc_write(pc_write_s), .pc_src(pc_src_s),
        .reg_write(reg_write_s), .mem_to_reg(mem_to_reg_s), .wwd_en(wwd_en_s),
        .halted(halted_s), .num_inst(num_inst_s)
    );

    // Vector layout: {stage, pc_src, read_m, write_m, iord, ir_write, pc_write, reg_write, mem_to_reg, wwd_en, halted}
    wire [13:0] outs   = {stage, pc_src, read_m, write_m, iord, ir_write, pc_write,
                          reg_write, mem_to_reg, wwd_en, halted};
    wire [13:0] outs_s = {stage_s, pc_src_s, read_m_s, write_m_s, iord_s, ir_write_s, pc_write_s,
                          reg_write_s, mem_to_reg_s, wwd_en_s, halted_s};

    localparam logic [8:0] NONE = 9'b0_0000_0000;
    localparam logic [8:0] RD   = 9'b1_0000_0000;
    localparam logic [8:0] WR   = 9'b0_1000_0000;
    localparam logic [8:0] IO   = 9'b0_0100_0000;
    localparam logic [8:0] IRW  = 9'b0_0010_0000;
    localparam logic [8:0] PCW  = 9'b0_0001_0000;
    localparam logic [8:0] RW   = 9'b0_0000_1000;
    localparam logic [8:0] M2R  = 9'b0_0000_0100;
    localparam logic [8:0] WWD  = 9'b0_0000_0010;
    localparam logic [8:0] HLT  = 9'b0_0000_0001;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    function automatic logic [13:0] mk(input logic [2:0] st, input logic [1:0] src, input logic [8:0] strobes);
        return {st, src, strobes};
    endfunction

    // Timing convention: tasks start and end at posedge+1; outputs are compared at posedge+2.

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 4'd15; func = 6'd0; branch_taken = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        #1;
        tests_run++;
        if (outs !== mk(S_IF, 2'd0, NONE) || outs_s !== mk(S_IF, 2'd0, NONE) || num_inst !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: outs=%h/%h num=%0d, expected %h num=0", outs, outs_s, num_inst, mk(S_IF, 2'd0, NONE));
        end
        mem_ready = 1'b0;
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (outs !== mk(S_IF, 2'd0, RD) || outs_s !== mk(S_IF, 2'd0, RD)) begin
            tests_failed++;
            $display("FAIL reset_release_fetch: outs=%h/%h, expected %h", outs, outs_s, mk(S_IF, 2'd0, RD));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [13:0] exp [4];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd0, NONE), mk(S_WB, 2'd0, PCW | RW)};
        opcode = 4'd15; func = 6'd0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL add cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (num_inst !== 16'd1 || num_inst_s !== 3'd1) begin
            tests_failed++;
            $display("FAIL add_num_inst: num=%0d/%0d, expected 1", num_inst, num_inst_s);
        end
    endtask

    task automatic test_lwd_wait();
        logic [13:0] exp [8];
        bit          rdy [8];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd0, NONE),
                mk(S_MEM, 2'd0, RD | IO), mk(S_MEM, 2'd0, RD | IO), mk(S_MEM, 2'd0, RD | IO),
                mk(S_MEM, 2'd0, RD | IO), mk(S_WB, 2'd0, PCW | RW | M2R)};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 4'd7; func = 6'd0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL lwd cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (num_inst !== 16'd2 || stage !== S_IF) begin
            tests_failed++;
            $display("FAIL lwd_retire: num=%0d stage=%0d, expected num=2 stage=0", num_inst, stage);
        end
    endtask

    task automatic test_branch();
        logic [13:0] exp [6];
        logic [3:0]  ops [2];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd1, PCW),
                mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd0, PCW)};
        ops = '{4'd1, 4'd0};
        mem_ready = 1'b1; func = 6'd0;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i / 3];
            branch_taken = (i < 3);
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL branch cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        branch_taken = 1'b0;
        tests_run++;
        if (num_inst !== 16'd4) begin
            tests_failed++;
            $display("FAIL branch_retire: num=%0d, expected 4", num_inst);
        end
    endtask

    task automatic test_jump();
        logic [13:0] exp [4];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd2, PCW | RW),
                mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd3, PCW | RW)};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = (i < 2) ? 4'd10 : 4'd15;
            func   = (i < 2) ? 6'd0  : 6'd26;
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL jal_jrl cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (num_inst !== 16'd6) begin
            tests_failed++;
            $display("FAIL jump_retire: num=%0d, expected 6", num_inst);
        end
    endtask

    task automatic test_wwd_nop();
        logic [13:0] exp [7];
        bit          rdy [7];
        logic [3:0]  ops [7];
        logic [5:0]  fns [7];
        exp = '{mk(S_IF, 2'd0, RD), mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, PCW | WWD),
                mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, PCW),
                mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, PCW)};
        rdy = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ops = '{4'd15, 4'd15, 4'd15, 4'd12, 4'd12, 4'd15, 4'd15};
        fns = '{6'd28, 6'd28, 6'd28, 6'd0, 6'd0, 6'd9, 6'd9};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; opcode = ops[i]; func = fns[i];
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL wwd_nop cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (num_inst !== 16'd9) begin
            tests_failed++;
            $display("FAIL wwd_nop_retire: num=%0d, expected 9", num_inst);
        end
    endtask

    task automatic test_swd();
        logic [13:0] exp [5];
        bit          rdy [5];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd0, NONE),
                mk(S_MEM, 2'd0, WR | IO), mk(S_MEM, 2'd0, WR | IO | PCW)};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 4'd8; func = 6'd0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL swd cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (num_inst !== 16'd10 || stage !== S_IF) begin
            tests_failed++;
            $display("FAIL swd_retire: num=%0d stage=%0d, expected num=10 stage=0", num_inst, stage);
        end
    endtask

    task automatic test_halt();
        logic [13:0] exp [2];
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE)};
        opcode = 4'd15; func = 6'd29; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL hlt cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            tests_run++;
            // 10 retired instructions: the 3-bit counter has wrapped to 2.
            if (outs !== mk(S_HALT, 2'd0, HLT) || outs_s !== mk(S_HALT, 2'd0, HLT) ||
                num_inst !== 16'd10 || num_inst_s !== 3'd2) begin
                tests_failed++;
                $display("FAIL halt_hold cycle %0d: outs=%h/%h num=%0d/%0d, expected %h num=10/2",
                         i, outs, outs_s, num_inst, num_inst_s, mk(S_HALT, 2'd0, HLT));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_swd();
        logic [13:0] exp [6];
        bit          rdy [6];
        logic [3:0]  ops [6];
        reset_n = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp = '{mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd2, PCW),
                mk(S_IF, 2'd0, RD | IRW), mk(S_ID, 2'd0, NONE), mk(S_EX, 2'd0, NONE), mk(S_MEM, 2'd0, WR | IO)};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ops = '{4'd9, 4'd9, 4'd8, 4'd8, 4'd8, 4'd8};
        func = 6'd0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i]; opcode = ops[i];
            #1;
            tests_run++;
            if (outs !== exp[i] || outs_s !== exp[i]) begin
                tests_failed++;
                $display("FAIL pre_reset_swd cycle %0d: outs=%h/%h, expected %h", i, outs, outs_s, exp[i]);
            end
            @(posedge clk); #1;
        end
        #1;
        tests_run++;
        if (write_m !== 1'b1 || num_inst !== 16'd1) begin
            tests_failed++;
            $display("FAIL swd_waiting: write_m=%b num=%0d, expected write_m=1 num=1", write_m, num_inst);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (outs !== mk(S_IF, 2'd0, NONE) || outs_s !== mk(S_IF, 2'd0, NONE) || num_inst !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_swd_reset: outs=%h/%h num=%0d, expected %h num=0", outs, outs_s, num_inst, mk(S_IF, 2'd0, NONE));
        end
        @(posedge clk); #1;
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        tests_run++;
        if (outs !== mk(S_IF, 2'd0, RD) || outs_s !== mk(S_IF, 2'd0, RD)) begin
            tests_failed++;
            $display("FAIL post_reset_fetch: outs=%h/%h, expected %h", outs, outs_s, mk(S_IF, 2'd0, RD));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lwd_wait();
        test_branch();
        test_jump();
        test_wwd_nop();
        test_swd();
        test_halt();
        test_reset_mid_swd();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
